// File: rtl/serial_addsub_ctrl_if.sv
// rtl/serial_addsub_ctrl_if.sv - request/response bundle between a requester and serial_addsub_ctrl
// Optional signed-overflow signal ovf present when SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             func;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic             ovf;

   modport master (
      output start, func, op_a, op_b,
      input  busy, done, result, carry_out, ovf
   );

   modport slave (
      input  start, func, op_a, op_b,
      output busy, done, result, carry_out, ovf
   );
`else
   modport master (
      output start, func, op_a, op_b,
      input  busy, done, result, carry_out
   );

   modport slave (
      input  start, func, op_a, op_b,
      output busy, done, result, carry_out
   );
`endif
endinterface

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial add/subtract sequencer driving one external 1-bit cell
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_addsub_ctrl_if.slave bus,
   output logic                cell_func,
   output logic                cell_in1,
   output logic                cell_in2,
   output logic                cell_in3,
   input  logic                cell_sum,
   input  logic                cell_cob
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_d;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             func_q;
   logic             carry_q;
   logic [CNT_W-1:0] count;
   logic             last_bit;

   // acc holds the WIDTH-1 low result bits collected so far; the final
   // bit arrives straight from the cell on the last SHIFT edge.
   logic [WIDTH-2:0] acc;
   logic [WIDTH-1:0] acc_cat;

   logic [WIDTH-1:0] result_q;
   logic             carry_out_q;

   assign last_bit = (count == CNT_W'(WIDTH - 1));
   assign acc_cat  = {cell_sum, acc};

   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.result    = result_q;
   assign bus.carry_out = carry_out_q;

`ifdef SERIAL_ADDSUB_OVF_EN
   logic ovf_q;

   // signed overflow: carry/borrow into the MSB differs from carry/borrow out of it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (state == S_SHIFT && last_bit) begin
         ovf_q <= carry_q ^ cell_cob;
      end
   end

   assign bus.ovf = ovf_q;
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // next-state logic and cell drive; cell inputs are only live in SHIFT
   always_comb begin
      state_d   = state;
      cell_func = 1'b0;
      cell_in1  = 1'b0;
      cell_in2  = 1'b0;
      cell_in3  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            cell_func = func_q;
            cell_in1  = a_sr[0];
            cell_in2  = b_sr[0];
            cell_in3  = carry_q;
            if (last_bit) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // operand latch, serial shift, and final result capture at DONE entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr        <= '0;
         b_sr        <= '0;
         func_q      <= 1'b0;
         carry_q     <= 1'b0;
         count       <= '0;
         acc         <= '0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  a_sr    <= bus.op_a;
                  b_sr    <= bus.op_b;
                  func_q  <= bus.func;
                  carry_q <= 1'b0;
                  count   <= '0;
               end
            end
            S_SHIFT: begin
               acc     <= acc_cat[WIDTH-1:1];
               carry_q <= cell_cob;
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               count   <= count + 1'b1;
               if (last_bit) begin
                  result_q    <= acc_cat;
                  carry_out_q <= cell_cob;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - self-checking bench for serial_addsub_ctrl with a behavioural 1-bit cell
module tb_serial_addsub_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   serial_addsub_ctrl_if #(.WIDTH(W)) bus ();

   logic cell_func;
   logic cell_in1;
   logic cell_in2;
   logic cell_in3;
   logic cell_sum;
   logic cell_cob;

   // external full adder/subtractor cell: func=1 add, func=0 in1-in2-in3
   always_comb begin
      cell_sum = cell_in1 ^ cell_in2 ^ cell_in3;
      if (cell_func) begin
         cell_cob = (cell_in1 & cell_in2) | (cell_in1 & cell_in3) | (cell_in2 & cell_in3);
      end else begin
         cell_cob = (~cell_in1 & cell_in2) | (~cell_in1 & cell_in3) | (cell_in2 & cell_in3);
      end
   end

   serial_addsub_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .cell_func (cell_func),
      .cell_in1  (cell_in1),
      .cell_in2  (cell_in2),
      .cell_in3  (cell_in3),
      .cell_sum  (cell_sum),
      .cell_cob  (cell_cob)
   );

   typedef struct {
      logic [W-1:0] res;
      logic         co;
      logic         ov;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int failures = 0;
   logic [W-1:0] last_res = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic f);
      logic [W:0] s;
      exp_t e;
      if (f) begin
         s    = {1'b0, a} + {1'b0, b};
         e.res = s[W-1:0];
         e.co  = s[W];
         e.ov  = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end else begin
         e.res = a - b;
         e.co  = (a < b);
         e.ov  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      sb.push_back(e);
   endtask

   task automatic check_cells_idle(input string tag);
      check(tag, 32'({cell_func, cell_in1, cell_in2, cell_in3}), 32'd0);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic f, input bit hold);
      logic c;
      exp_t e;
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check_cells_idle("idle_cells");
      bus.start = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
      bus.func  = f;
      push_exp(a, b, f);
      c = 1'b0;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         if (i == 0) begin
            if (hold) begin
               bus.op_a = 8'hAA;
            end else begin
               bus.start = 1'b0;
            end
         end
         check("shift_busy", 32'(bus.busy), 32'd1);
         check("shift_done", 32'(bus.done), 32'd0);
         check("cell_func", 32'(cell_func), 32'(f));
         check("cell_in1", 32'(cell_in1), 32'(a[i]));
         check("cell_in2", 32'(cell_in2), 32'(b[i]));
         check("cell_in3", 32'(cell_in3), 32'(c));
         check("result_hold", 32'(bus.result), 32'(last_res));
         if (f) begin
            c = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
         end else begin
            c = (~a[i] & b[i]) | (~a[i] & c) | (b[i] & c);
         end
      end
      @(negedge clk);
      check("done_pulse", 32'(bus.done), 32'd1);
      check("done_busy", 32'(bus.busy), 32'd1);
      check_cells_idle("done_cells");
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("result", 32'(bus.result), 32'(e.res));
         check("carry_out", 32'(bus.carry_out), 32'(e.co));
`ifdef SERIAL_ADDSUB_OVF_EN
         check("ovf", 32'(bus.ovf), 32'(e.ov));
`endif
         last_res = e.res;
      end
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      bus.start = 1'b0;
      bus.func  = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      rst_n     = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_carry", 32'(bus.carry_out), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
      check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
      check_cells_idle("rst_cells");
      rst_n = 1'b1;

      run_op(8'h35, 8'h4A, 1'b1, 1'b0);
      run_op(8'hFF, 8'h01, 1'b1, 1'b0);
      run_op(8'h7F, 8'h01, 1'b1, 1'b0);
      run_op(8'h05, 8'h03, 1'b0, 1'b0);
      run_op(8'h03, 8'h05, 1'b0, 1'b0);
      run_op(8'h80, 8'h01, 1'b0, 1'b0);

      // start held high through SHIFT and DONE; the second op only begins from IDLE
      run_op(8'h10, 8'h20, 1'b1, 1'b1);
      run_op(8'hAA, 8'h20, 1'b1, 1'b0);

      // reset during the 4th SHIFT cycle abandons the operation
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = 8'h12;
      bus.op_b  = 8'h34;
      bus.func  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) bus.start = 1'b0;
      end
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      check("midrst_result", 32'(bus.result), 32'd0);
      check("midrst_carry", 32'(bus.carry_out), 32'd0);
      check_cells_idle("midrst_cells");
      last_res = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_hold_done", 32'(bus.done), 32'd0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("post_rst_done", 32'(bus.done), 32'd0);
         check("post_rst_busy", 32'(bus.busy), 32'd0);
      end

      run_op(8'hC3, 8'h3C, 1'b0, 1'b0);

      for (int k = 0; k < 6; k++) begin
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         run_op(ra, rb, 1'(k % 2), 1'b0);
      end

      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
